// File: rtl/snake_engine.sv
// -----------------------------------------------------------------------------
// snake_engine
//
// Snake movement/collision engine on a GRID_W x GRID_H grid. The body is stored
// as a head-first list of linear positions (row*GRID_W + col). Each accepted
// step request takes two cycles:
//   - CHECK resolves the heading, builds the candidate head, and decides the
//     outcome (wall, self-collision, food).
//   - MOVE shifts the body.
// A collision parks the engine in DEAD until reset.
//
// Configuration:
//   SNAKE_WRAP_EN  - when defined, leaving the grid wraps to the opposite edge
//                    instead of killing the snake. Self-collision still kills.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   step       in   request to advance one move
//   dir        in   requested direction: 00 left, 01 right, 10 up, 11 down
//   food_valid in   food_pos is meaningful
//   food_pos   in   food position
//   body       out  MAX_LEN segments, slice i = segment i, i=0 is the head;
//                   unused slices read all-ones
//   len        out  current segment count
//   busy       out  step in progress
//   done       out  one-cycle pulse when a step completes (move or death)
//   ate        out  one-cycle pulse with done when food was consumed
//   dead       out  sticky collision flag
// -----------------------------------------------------------------------------
module snake_engine #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int MAX_LEN  = 16,
    parameter int POS_W    = 10,
    parameter int INIT_LEN = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step,
    input  logic [1:0]                   dir,
    input  logic                         food_valid,
    input  logic [POS_W-1:0]             food_pos,
    output logic [MAX_LEN*POS_W-1:0]     body,
    output logic [$clog2(MAX_LEN+1)-1:0] len,
    output logic                         busy,
    output logic                         done,
    output logic                         ate,
    output logic                         dead
);

    localparam int LEN_W = $clog2(MAX_LEN+1);

    localparam logic [POS_W-1:0] ONE_P    = POS_W'(1);
    localparam logic [POS_W-1:0] W_P      = POS_W'(GRID_W);
    localparam logic [POS_W-1:0] LAST_COL = POS_W'(GRID_W-1);
    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(GRID_H-1);
    localparam logic [POS_W-1:0] COL_SPAN = POS_W'((GRID_H-1)*GRID_W);
    localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_MOVE,
        S_DEAD
    } state_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    state_t             state_q,   state_d;
    dir_t               heading_q, heading_d;
    dir_t               dir_q,     dir_d;
    logic               fv_q,      fv_d;
    logic [POS_W-1:0]   fp_q,      fp_d;
    logic [POS_W-1:0]   cand_q,    cand_d;
    logic               grow_q,    grow_d;
    logic [POS_W-1:0]   seg_q [MAX_LEN];
    logic [POS_W-1:0]   seg_d [MAX_LEN];
    logic [LEN_W-1:0]   len_q,     len_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               ate_q,     ate_d;
    logic               dead_q,    dead_d;

    // CHECK-stage evaluation, based on latched request and current body
    dir_t               eff_dir;
    logic [POS_W-1:0]   head;
    logic [POS_W-1:0]   col;
    logic [POS_W-1:0]   row;
    logic               wall;
    logic [POS_W-1:0]   cand;
    logic               grow;
    logic               hit;
    logic               kill;

    always_comb begin
        // Left/right and up/down encodings differ only in bit 0, so an exact
        // reversal is a request that differs from the heading in bit 0 alone.
        eff_dir = ((2'(dir_q) ^ 2'(heading_q)) == 2'b01) ? heading_q : dir_q;

        head = seg_q[0];
        col  = head % W_P;
        row  = head / W_P;
        wall = 1'b0;
        cand = head;

        unique case (eff_dir)
            DIR_LEFT: begin
                wall = (col == '0);
                cand = head - ONE_P;
`ifdef SNAKE_WRAP_EN
                if (wall) cand = head + LAST_COL;
`endif
            end
            DIR_RIGHT: begin
                wall = (col == LAST_COL);
                cand = head + ONE_P;
`ifdef SNAKE_WRAP_EN
                if (wall) cand = head - LAST_COL;
`endif
            end
            DIR_UP: begin
                wall = (row == '0);
                cand = head - W_P;
`ifdef SNAKE_WRAP_EN
                if (wall) cand = head + COL_SPAN;
`endif
            end
            default: begin
                wall = (row == LAST_ROW);
                cand = head + W_P;
`ifdef SNAKE_WRAP_EN
                if (wall) cand = head - COL_SPAN;
`endif
            end
        endcase

        grow = fv_q && (cand == fp_q);

        // The tail segment vacates during the move unless the snake grows,
        // so it only counts as an obstacle when growing.
        hit = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((seg_q[i] == cand) &&
                ((i + 1 < 32'(len_q)) || (grow && (i + 1 == 32'(len_q)))))
                hit = 1'b1;
        end

`ifdef SNAKE_WRAP_EN
        kill = hit;
`else
        kill = hit || wall;
`endif
    end

    always_comb begin
        state_d   = state_q;
        heading_d = heading_q;
        dir_d     = dir_q;
        fv_d      = fv_q;
        fp_d      = fp_q;
        cand_d    = cand_q;
        grow_d    = grow_q;
        seg_d     = seg_q;
        len_d     = len_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ate_d     = 1'b0;
        dead_d    = dead_q;

        unique case (state_q)
            S_IDLE: begin
                if (step) begin
                    dir_d   = dir_t'(dir);
                    fv_d    = food_valid;
                    fp_d    = food_pos;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                heading_d = eff_dir;
                cand_d    = cand;
                grow_d    = grow;
                if (kill) begin
                    dead_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DEAD;
                end else begin
                    state_d = S_MOVE;
                end
            end

            S_MOVE: begin
                if (grow_q && (len_q < MAX_L))
                    len_d = len_q + LEN_W'(1);
                seg_d[0] = cand_q;
                for (int unsigned i = 1; i < MAX_LEN; i++)
                    seg_d[i] = seg_q[i-1];
                // Shifting drags the old tail into the first unused slot;
                // blank everything past the new length.
                for (int unsigned i = 0; i < MAX_LEN; i++) begin
                    if (i >= 32'(len_d))
                        seg_d[i] = '1;
                end
                done_d = 1'b1;
                ate_d  = grow_q;
                // The completing edge is also the idle boundary, so a request
                // present here is taken to keep one step per two cycles.
                if (step) begin
                    dir_d   = dir_t'(dir);
                    fv_d    = food_valid;
                    fp_d    = food_pos;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                // DEAD: hold everything until reset
                state_d = S_DEAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            heading_q <= DIR_RIGHT;
            dir_q     <= DIR_RIGHT;
            fv_q      <= 1'b0;
            fp_q      <= '0;
            cand_q    <= '0;
            grow_q    <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN)
                    seg_q[i] <= POS_W'(INIT_LEN - 1 - i);
                else
                    seg_q[i] <= '1;
            end
            len_q     <= LEN_W'(INIT_LEN);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ate_q     <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            heading_q <= heading_d;
            dir_q     <= dir_d;
            fv_q      <= fv_d;
            fp_q      <= fp_d;
            cand_q    <= cand_d;
            grow_q    <= grow_d;
            seg_q     <= seg_d;
            len_q     <= len_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ate_q     <= ate_d;
            dead_q    <= dead_d;
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_body
        assign body[g*POS_W +: POS_W] = seg_q[g];
    end

    assign len  = len_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ate  = ate_q;
    assign dead = dead_q;

endmodule

// File: tb/tb_snake_engine.sv
// -----------------------------------------------------------------------------
// tb_snake_engine
//
// Directed and randomized steps against a queue-based model of the snake.
// The model keeps the body as a head-first list of positions and applies the
// movement rules with row/column arithmetic.
// -----------------------------------------------------------------------------
module tb_snake_engine;

    localparam int GW = 32;
    localparam int GH = 24;
    localparam int ML = 16;
    localparam int PW = 10;
    localparam int IL = 5;
    localparam int LW = $clog2(ML+1);
    localparam int BW = ML*PW;

    logic          clk;
    logic          rst;
    logic          step;
    logic [1:0]    dir;
    logic          food_valid;
    logic [PW-1:0] food_pos;
    logic [BW-1:0] body;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          ate;
    logic          dead;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // model state
    int unsigned mq[$];
    logic [1:0]  mhead;
    bit          mdead;

    snake_engine #(
        .GRID_W   (GW),
        .GRID_H   (GH),
        .MAX_LEN  (ML),
        .POS_W    (PW),
        .INIT_LEN (IL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .dir        (dir),
        .food_valid (food_valid),
        .food_pos   (food_pos),
        .body       (body),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .ate        (ate),
        .dead       (dead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] exp_body();
        logic [BW-1:0] v;
        v = '1;
        for (int i = 0; i < mq.size(); i++)
            v[i*PW +: PW] = PW'(mq[i]);
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < IL; i++)
            mq.push_back(IL - 1 - i);
        mhead = 2'b01;
        mdead = 1'b0;
    endtask

    // Apply one move to the model; reports whether it killed and whether it ate.
    task automatic model_step(input logic [1:0] d, input bit fv, input int unsigned fp,
                              output bit kill, output bit grow);
        int col;
        int row;
        int nc;
        int nr;
        bit wall;
        bit hit;
        int unsigned c;
        logic [1:0] e;
        col  = int'(mq[0]) % GW;
        row  = int'(mq[0]) / GW;
        nc   = col;
        nr   = row;
        wall = 1'b0;
        e    = d;
        if ((d == 2'd0 && mhead == 2'd1) || (d == 2'd1 && mhead == 2'd0) ||
            (d == 2'd2 && mhead == 2'd3) || (d == 2'd3 && mhead == 2'd2))
            e = mhead;
        mhead = e;
        case (e)
            2'd0: if (col == 0)      begin wall = 1; nc = GW-1; end else nc = col - 1;
            2'd1: if (col == GW-1)   begin wall = 1; nc = 0;    end else nc = col + 1;
            2'd2: if (row == 0)      begin wall = 1; nr = GH-1; end else nr = row - 1;
            default: if (row == GH-1) begin wall = 1; nr = 0;   end else nr = row + 1;
        endcase
        c    = int'(nr * GW + nc);
        grow = fv && (c == fp);
        hit  = 1'b0;
        for (int k = 0; k < mq.size(); k++)
            if (mq[k] == c && (k < mq.size() - 1 || grow)) hit = 1'b1;
`ifdef SNAKE_WRAP_EN
        kill = hit;
`else
        kill = hit || wall;
`endif
        if (kill) begin
            mdead = 1'b1;
        end else begin
            mq.push_front(c);
            if (!grow || mq.size() > ML) void'(mq.pop_back());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step = 1'b0;
        food_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_body"}, body, exp_body());
        chk({tag, "_len"},  len, mq.size());
        chk({tag, "_dead"}, dead, mdead);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_step(input logic [1:0] d, input bit fv, input int unsigned fp, input string tag);
        bit was_dead;
        bit kill;
        bit grow;
        int unsigned lat;
        int unsigned exp_lat;
        was_dead = mdead;
        kill = 1'b0;
        grow = 1'b0;
        if (!was_dead) model_step(d, fv, fp, kill, grow);
        exp_lat = was_dead ? 4 : (kill ? 1 : 2);
        @(negedge clk);
        step = 1'b1;
        dir = d;
        food_valid = fv;
        food_pos = PW'(fp);
        @(posedge clk);
        #1;
        step = 1'b0;
        food_valid = 1'b0;
        chk({tag, "_busy_acc"}, busy, !was_dead);
        lat = 0;
        while (done !== 1'b1 && lat < 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_ate"}, ate, (!was_dead && !kill && grow));
        check_state(tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, done, 0);
    endtask

    initial begin
        logic [1:0]  d;
        bit          fv;
        int unsigned fp;
        int          off;
        bit          seen;

        rst = 1'b1;
        step = 1'b0;
        dir = 2'b00;
        food_valid = 1'b0;
        food_pos = '0;
        model_reset();

        // reset state
        do_reset();
        #1;
        chk("rst_body", body, exp_body());
        chk("rst_len", len, 5);
        chk("rst_flags", {busy, done, ate, dead}, 4'b0000);

        // plain right step: body 5,4,3,2,1
        do_step(2'b01, 1'b0, 0, "right");
        chk("right_head", body[PW-1:0], 5);

        // reversal from reset keeps heading right
        do_reset();
        do_step(2'b00, 1'b0, 0, "reverse");
        chk("reverse_head", body[PW-1:0], 5);
        chk("reverse_alive", dead, 0);

        // eat at 5: len 6, tail kept
        do_reset();
        do_step(2'b01, 1'b1, 5, "eat");
        chk("eat_len", len, 6);
        chk("eat_tail", body[5*PW +: PW], 0);

        // run along row 0 to col 31, then push into the right wall
        do_reset();
        for (int k = 0; k < 27; k++) do_step(2'b01, 1'b0, 0, "run");
        chk("run_head", body[PW-1:0], 31);
        do_step(2'b01, 1'b0, 0, "wall");
`ifdef SNAKE_WRAP_EN
        chk("wall_dead", dead, 0);
        chk("wall_head", body[PW-1:0], 0);
`else
        chk("wall_dead", dead, 1);
        chk("wall_head", body[PW-1:0], 31);
`endif
        do_step(2'b10, 1'b0, 0, "post_wall");

        // down, left, up runs into old segment 3
        do_reset();
        do_step(2'b11, 1'b0, 0, "u_down");
        do_step(2'b00, 1'b0, 0, "u_left");
        do_step(2'b10, 1'b0, 0, "u_up");
        chk("u_dead", dead, 1);
        do_step(2'b11, 1'b0, 0, "dead_hold");

        // reset one cycle after acceptance aborts the step silently
        do_reset();
        @(negedge clk);
        step = 1'b1;
        dir = 2'b01;
        @(posedge clk);
        #1;
        step = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        @(posedge clk);
        #1;
        if (done === 1'b1) seen = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        model_reset();
        chk("abort_no_done", seen, 0);
        check_state("abort");

        // grow to saturation while heading right along row 0
        do_reset();
        for (int k = 0; k < 13; k++) do_step(2'b01, 1'b1, mq[0] + 1, "sat");
        chk("sat_len", len, ML);

        // randomized play
        do_reset();
        for (int s = 0; s < 150; s++) begin
            d = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) d = mhead;
            fv = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: off = 1;
                1: off = -1;
                2: off = GW;
                3: off = -GW;
                default: off = int'($urandom_range(0, GW*GH - 1));
            endcase
            fp = int'(mq[0] + GW*GH + off) % (GW*GH);
            do_step(d, fv, fp, "rnd");
            if (mdead) begin
                do_step(2'($urandom_range(0, 3)), 1'b0, 0, "rnd_dead");
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 The module SHALL have parameter GRID_W, default 32, meaning grid columns.
REQ-002 The module SHALL have parameter GRID_H, default 24, meaning grid rows.
REQ-003 The module SHALL have parameter MAX_LEN, default 16, meaning the maximum number of segments.
REQ-004 The module SHALL have parameter POS_W, default 10, meaning segment position width; position = row*GRID_W + col.
REQ-005 The module SHALL have parameter INIT_LEN, default 5, meaning the length after reset; legal range 2..MAX_LEN and INIT_LEN <= GRID_W.
REQ-006 The module SHALL have one clock, clk (input, 1 bit), with all logic on its rising edge.
REQ-007 The module SHALL have rst (input, 1 bit), a synchronous, active-high reset.
REQ-008 The module SHALL have step (input, 1 bit), a request to advance one move.
REQ-009 The module SHALL have dir (input, 2 bits): 00 = left, 01 = right, 10 = up, 11 = down.
REQ-010 The module SHALL have food_valid (input, 1 bit), meaning food_pos is meaningful.
REQ-011 The module SHALL have food_pos (input, POS_W bits), the food position.
REQ-012 The module SHALL have body (output, MAX_LEN*POS_W bits), where slice i is segment i; i=0 is the head.
REQ-013 The module SHALL have len (output, $clog2(MAX_LEN+1) bits), the current segment count.
REQ-014 The module SHALL have busy (output, 1 bit), high while a step is in progress.
REQ-015 The module SHALL have done (output, 1 bit), a one-cycle pulse when a step completes.
REQ-016 The module SHALL have ate (output, 1 bit), a one-cycle pulse coincident with done when food is consumed.
REQ-017 The module SHALL have dead (output, 1 bit), a sticky collision flag.

Function
REQ-018 The FSM SHALL have states IDLE, CHECK, MOVE and DEAD.
REQ-019 In IDLE, step=1 SHALL latch dir and food inputs, set busy, and go to CHECK; step outside IDLE SHALL be ignored.
REQ-020 In CHECK, if dir is the exact opposite of the stored heading, the engine SHALL keep the heading; otherwise heading SHALL become dir.
REQ-021 In CHECK, the candidate head SHALL be head +/-1 (left/right) or +/-GRID_W (up/down).
REQ-022 A wall hit SHALL be detected as left at col 0, right at col GRID_W-1, up at row 0, or down at row GRID_H-1.
REQ-023 grow SHALL = food_valid && candidate == food_pos.
REQ-024 Self-collision SHALL be candidate equal to segment i for i < len-1; segment len-1 SHALL also be compared when grow=1.
REQ-025 Wall hit or self-collision SHALL go to DEAD; otherwise the FSM SHALL go to MOVE.
REQ-026 In MOVE: segment i SHALL take segment i-1 for 1 <= i < MAX_LEN; segment 0 SHALL take the candidate; the FSM SHALL return to IDLE.
REQ-027 MOVE SHALL pulse done, clear busy, and pulse ate if grow.
REQ-028 When grow is asserted and len < MAX_LEN, MOVE SHALL increment len; at len = MAX_LEN, len SHALL saturate, the tail SHALL drop and ate SHALL still pulse.
REQ-029 Slices at index >= len SHALL read all-ones.
REQ-030 Latency SHALL be: step accepted at edge n, done/ate/body/len update at edge n+2, next step accepted at n+2.
REQ-031 Entering DEAD SHALL pulse done, set dead, clear busy, and leave body and len unchanged.
REQ-032 DEAD SHALL hold until rst, ignoring step.

Reset
REQ-033 On rst, segment i SHALL = INIT_LEN-1-i for i < INIT_LEN, others all-ones.
REQ-034 On rst, heading SHALL = right, len = INIT_LEN, busy/done/ate/dead = 0, and the FSM SHALL enter IDLE.
REQ-035 rst SHALL take priority in any state, including mid-step in CHECK/MOVE; the aborted step SHALL produce no done pulse.

Configuration
REQ-036 The macro SNAKE_WRAP_EN SHALL select wall behaviour.
REQ-037 When SNAKE_WRAP_EN is defined, wall hits SHALL NOT kill; the head SHALL wrap: col 0 left -> col GRID_W-1, col GRID_W-1 right -> col 0, row 0 up -> row GRID_H-1, row GRID_H-1 down -> row 0, with the same row/col kept; self-collision SHALL still kill.
REQ-038 When SNAKE_WRAP_EN is undefined, wall hits SHALL enter DEAD per REQ-022.

Verification
REQ-039 rst then step with dir=01 SHALL give done at +2 cycles, body[0..4] = 5,4,3,2,1, len = 5.
REQ-040 From reset, step with dir=00 SHALL be treated as a reversal: the head SHALL move right to 5, and dead SHALL stay 0.
REQ-041 food_valid=1, food_pos=5, step with dir=01 SHALL give ate = 1, len = 6, body[0..5] = 5,4,3,2,1,0.
REQ-042 With the head at 31 (row 0, col 31), step with dir=01 SHALL set dead = 1 with body unchanged; with SNAKE_WRAP_EN defined it SHALL instead give head = 0 and dead = 0.
REQ-043 With len=5, steps down, left, up (head hits old segment 3) SHALL set dead = 1 on the third step.
REQ-044 rst asserted the cycle after step is accepted SHALL give no done pulse and the reset body 4,3,2,1,0.
